t5_dmem: RTL and testbench
==========================

T5_DMEM -- requirements
Module: t5_dmem

Interface
REQ-001 Parameter XLEN, 32, data and address width.
REQ-002 Parameter TOUT, 255, bus watchdog limit in cycles (1..255).
REQ-003 sclk  in  1  sole clock, rising edge.
REQ-004 srst  in  1  reset, asynchronous, active-high.
REQ-005 sena  in  1  pipeline advance from other hazard logic.
REQ-006 xvld  in  1  X-stage instruction valid.
REQ-007 xopc  in  5  opcode[6:2]; 5'h00 load, 5'h08 store.
REQ-008 xfn3  in  3  funct3[14:12]; [13:12] size, [14] unsigned.
REQ-009 xadd  in  XLEN  effective address.
REQ-010 xrs2  in  XLEN  store source.
REQ-011 dwb_cyc, dwb_stb, dwb_wre  out  1 each  Wishbone master controls.
REQ-012 dwb_adr  out  XLEN  word address, bits [1:0] forced 0.
REQ-013 dwb_sel  out  4  byte lanes.
REQ-014 dwb_dto  out  XLEN  write data.
REQ-015 dwb_dti  in  XLEN  read data; dwb_ack, dwb_err  in  1 each.
REQ-016 xsel  out  4  lane select to writeback extension.
REQ-017 ddat  out  XLEN  read data presented to writeback.
REQ-018 dstl  out  1  stall request; derr, dmis  out  1  one-cycle error pulses.

Function
REQ-019 Request (req) SHALL be xvld and xopc is load or store.
REQ-020 Lane select SHALL be: size 0 -> 1<<xadd[1:0]; size 1 -> 4'h3 if xadd[1]=0 else 4'hC; size 2 -> 4'hF.
REQ-021 Misaligned (half with xadd[0]=1, word with xadd[1:0]!=0) SHALL issue no bus cycle, pulse dmis one cycle, keep dstl low.
REQ-022 Store data SHALL be replicated: byte {4{xrs2[7:0]}}, half {2{xrs2[15:0]}}, word xrs2.
REQ-023 FSM states IDLE, BUSY, HOLD; reset state IDLE.
REQ-024 IDLE: aligned req SHALL latch address, sel, data, we and enter BUSY next edge; dstl high that cycle.
REQ-025 BUSY: dwb_cyc=dwb_stb=1 with latched values; dstl high until the ack cycle.
REQ-026 BUSY with dwb_ack: dstl low that cycle; ddat=dwb_dti combinationally; if sena then IDLE else HOLD with dwb_dti captured.
REQ-027 HOLD: bus idle, dstl low, ddat=captured data, xsel=latched sel; leave to IDLE on first sena.
REQ-028 xsel SHALL be latched sel in BUSY/HOLD, combinational sel in IDLE.
REQ-029 Watchdog counter SHALL clear on BUSY entry, increment each BUSY cycle; reaching TOUT aborts to IDLE with derr pulse.
REQ-030 dwb_err in BUSY SHALL abort to IDLE, pulse derr, drop dstl; err with ack simultaneously treated as err.
REQ-031 dwb_cyc/dwb_stb SHALL be registered; never asserted outside BUSY.

Reset
REQ-032 Reset SHALL force IDLE, all bus outputs 0, xsel 0, ddat 0, dstl/derr/dmis 0, counter 0.
REQ-033 Reset mid-BUSY SHALL drop dwb_cyc/dwb_stb immediately (asynchronously).

Structure
REQ-034 Opcode constants, size encodings, FSM state encoding SHALL live in shared package t5_pkg.
REQ-035 Lane/data steering SHALL be sub-module t5_dmux (combinational); FSM, watchdog, latches in t5_dmem.

Verification
REQ-036 sb x5 to 0x1002, ack after 2 cycles -> dwb_sel=4'h4, dwb_dto=0x05050505, dwb_wre=1, dstl high 3 cycles.
REQ-037 lw 0x100 with sena low at ack, dwb_dti=0xDEADBEEF -> HOLD, ddat stays 0xDEADBEEF until sena, xsel=4'hF.
REQ-038 lh at 0x103 -> dmis one-cycle pulse, dwb_cyc never high, dstl low.
REQ-039 No ack, TOUT=4 -> abort after 4 BUSY cycles, derr pulse, state IDLE.
REQ-040 Assert srst during BUSY -> dwb_cyc/dwb_stb/dstl low before next edge.
REQ-041 dwb_err and dwb_ack same cycle -> derr pulse, no HOLD entry.

Source files
------------

// File: rtl/t5_pkg.sv
// Shared opcode, access-size and FSM state encodings for the data-memory port.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } dmem_st_t;

endpackage

// File: rtl/t5_dmux.sv
// Byte-lane select, store-data replication and misalignment detection (combinational).
module t5_dmux
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      sel,
  output logic [XLEN-1:0] dto,
  output logic            mis
);

  always_comb begin
    sel = 4'hF;
    dto = rs2;
    mis = 1'b0;
    case (size)
      SZ_B: begin
        sel = 4'b0001 << off;
        dto = {(XLEN/8){rs2[7:0]}};
      end
      SZ_H: begin
        sel = off[1] ? 4'hC : 4'h3;
        dto = {(XLEN/16){rs2[15:0]}};
        mis = off[0];
      end
      default: begin
        // size 3 is not a legal RV32 access; it is handled as a word
        sel = 4'hF;
        dto = rs2;
        mis = |off;
      end
    endcase
  end

endmodule

// File: rtl/t5_dmem.sv
// X-stage load/store unit driving a Wishbone master port with stall, hold and watchdog abort.
module t5_dmem
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TOUT = 255
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            xvld,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xadd,
  input  logic [XLEN-1:0] xrs2,
  output logic            dwb_cyc,
  output logic            dwb_stb,
  output logic            dwb_wre,
  output logic [XLEN-1:0] dwb_adr,
  output logic [3:0]      dwb_sel,
  output logic [XLEN-1:0] dwb_dto,
  input  logic [XLEN-1:0] dwb_dti,
  input  logic            dwb_ack,
  input  logic            dwb_err,
  output logic [3:0]      xsel,
  output logic [XLEN-1:0] ddat,
  output logic            dstl,
  output logic            derr,
  output logic            dmis
);

  localparam logic [7:0] TLIM = 8'(TOUT - 1);

  dmem_st_t        st, st_nxt;
  logic            req, mis;
  logic [3:0]      sel_c, sel_q;
  logic [XLEN-1:0] dto_c, dto_q, adr_q, dat_q;
  logic            we_q, cyc_q;
  logic [7:0]      cnt;

  // sign/zero extension happens in writeback; the unsigned flag is not needed here
  logic unused_fn3;
  assign unused_fn3 = xfn3[2];

  assign req = xvld && (xopc == OPC_LOAD || xopc == OPC_STORE);

  t5_dmux #(.XLEN(XLEN)) u_dmux (
    .size (xfn3[1:0]),
    .off  (xadd[1:0]),
    .rs2  (xrs2),
    .sel  (sel_c),
    .dto  (dto_c),
    .mis  (mis)
  );

  always_comb begin
    st_nxt = st;
    dstl   = 1'b0;
    derr   = 1'b0;
    dmis   = 1'b0;
    xsel   = sel_c;
    ddat   = dat_q;
    case (st)
      ST_IDLE: begin
        if (req) begin
          if (mis) begin
            dmis = 1'b1;
          end else begin
            dstl   = 1'b1;
            st_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        xsel = sel_q;
        // error beats ack; an ack in the final watchdog cycle still completes
        if (dwb_err || (!dwb_ack && cnt == TLIM)) begin
          derr   = 1'b1;
          st_nxt = ST_IDLE;
        end else if (dwb_ack) begin
          ddat   = dwb_dti;
          st_nxt = sena ? ST_IDLE : ST_HOLD;
        end else begin
          dstl = 1'b1;
        end
      end
      ST_HOLD: begin
        xsel = sel_q;
        if (sena) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
    // keep pipeline-facing strobes quiet while reset is held, even with xvld high
    if (srst) begin
      dstl = 1'b0;
      derr = 1'b0;
      dmis = 1'b0;
      xsel = 4'h0;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      st    <= ST_IDLE;
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      sel_q <= 4'h0;
      dto_q <= '0;
      dat_q <= '0;
      cnt   <= 8'd0;
    end else begin
      st    <= st_nxt;
      cyc_q <= (st_nxt == ST_BUSY);
      if (st == ST_IDLE && st_nxt == ST_BUSY) begin
        adr_q <= {xadd[XLEN-1:2], 2'b00};
        sel_q <= sel_c;
        dto_q <= dto_c;
        we_q  <= (xopc == OPC_STORE);
        cnt   <= 8'd0;
      end else if (st == ST_BUSY) begin
        cnt <= cnt + 8'd1;
      end
      if (st == ST_BUSY && dwb_ack && !dwb_err) dat_q <= dwb_dti;
    end
  end

  assign dwb_cyc = cyc_q;
  assign dwb_stb = cyc_q;
  assign dwb_wre = we_q;
  assign dwb_adr = adr_q;
  assign dwb_sel = sel_q;
  assign dwb_dto = dto_q;

endmodule

// File: tb/tb_t5_dmem.sv
// Directed bench for t5_dmem: lane-select table plus store, hold, misalign, watchdog, reset and error sequences.
module tb_t5_dmem;
  logic        sclk = 1'b0;
  logic        srst, sena, xvld;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] xadd, xrs2;
  logic        dwb_cyc, dwb_stb, dwb_wre;
  logic [31:0] dwb_adr, dwb_dto, dwb_dti;
  logic [3:0]  dwb_sel, xsel;
  logic        dwb_ack, dwb_err;
  logic [31:0] ddat;
  logic        dstl, derr, dmis;

  int n_pass = 0;
  int n_tot  = 0;

  t5_dmem #(.XLEN(32), .TOUT(4)) dut (
    .sclk(sclk), .srst(srst), .sena(sena), .xvld(xvld), .xopc(xopc), .xfn3(xfn3),
    .xadd(xadd), .xrs2(xrs2), .dwb_cyc(dwb_cyc), .dwb_stb(dwb_stb), .dwb_wre(dwb_wre),
    .dwb_adr(dwb_adr), .dwb_sel(dwb_sel), .dwb_dto(dwb_dto), .dwb_dti(dwb_dti),
    .dwb_ack(dwb_ack), .dwb_err(dwb_err), .xsel(xsel), .ddat(ddat), .dstl(dstl),
    .derr(derr), .dmis(dmis)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic        vld;
    logic [4:0]  opc;
    logic [2:0]  fn3;
    logic [31:0] add;
    logic [3:0]  sel;
    logic        stl;
    logic        mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic issue(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] add,
                       input logic [31:0] rs2);
    xvld = 1'b1; xopc = opc; xfn3 = fn3; xadd = add; xrs2 = rs2;
  endtask

  vec_t vt[10];
  int   stl_cnt, busy_cnt, derr_cnt, derr_at;

  initial begin
    vt[0] = '{1'b1, 5'h00, 3'd0, 32'h0000_1000, 4'h1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 5'h00, 3'd4, 32'h0000_1003, 4'h8, 1'b1, 1'b0};
    vt[2] = '{1'b1, 5'h08, 3'd0, 32'h0000_1001, 4'h2, 1'b1, 1'b0};
    vt[3] = '{1'b1, 5'h00, 3'd1, 32'h0000_2002, 4'hC, 1'b1, 1'b0};
    vt[4] = '{1'b1, 5'h00, 3'd5, 32'h0000_2000, 4'h3, 1'b1, 1'b0};
    vt[5] = '{1'b1, 5'h08, 3'd1, 32'h0000_2001, 4'h3, 1'b0, 1'b1};
    vt[6] = '{1'b1, 5'h00, 3'd2, 32'h0000_3000, 4'hF, 1'b1, 1'b0};
    vt[7] = '{1'b1, 5'h08, 3'd2, 32'h0000_3002, 4'hF, 1'b0, 1'b1};
    vt[8] = '{1'b0, 5'h00, 3'd2, 32'h0000_3000, 4'hF, 1'b0, 1'b0};
    vt[9] = '{1'b1, 5'h04, 3'd2, 32'h0000_3001, 4'hF, 1'b0, 1'b0};

    srst = 1'b1; sena = 1'b1; xvld = 1'b0; xopc = 5'h00; xfn3 = 3'd0;
    xadd = 32'h0; xrs2 = 32'h0; dwb_dti = 32'h0; dwb_ack = 1'b0; dwb_err = 1'b0;

    // reset state
    @(negedge sclk);
    chk("rst_cyc", {31'b0, dwb_cyc}, 32'd0);
    chk("rst_stb", {31'b0, dwb_stb}, 32'd0);
    chk("rst_wre", {31'b0, dwb_wre}, 32'd0);
    chk("rst_adr", dwb_adr, 32'd0);
    chk("rst_sel", {28'b0, dwb_sel}, 32'd0);
    chk("rst_dto", dwb_dto, 32'd0);
    chk("rst_xsel", {28'b0, xsel}, 32'd0);
    chk("rst_ddat", ddat, 32'd0);
    chk("rst_strobes", {29'b0, dstl, derr, dmis}, 32'd0);
    step();
    srst = 1'b0;
    step();

    // lane select / stall / misalign decode in IDLE
    for (int i = 0; i < 10; i++) begin
      xvld = vt[i].vld; xopc = vt[i].opc; xfn3 = vt[i].fn3; xadd = vt[i].add; xrs2 = 32'h0;
      @(negedge sclk);
      chk($sformatf("tbl%0d_xsel", i), {28'b0, xsel}, {28'b0, vt[i].sel});
      chk($sformatf("tbl%0d_dstl", i), {31'b0, dstl}, {31'b0, vt[i].stl});
      chk($sformatf("tbl%0d_dmis", i), {31'b0, dmis}, {31'b0, vt[i].mis});
      chk($sformatf("tbl%0d_cyc", i), {31'b0, dwb_cyc}, 32'd0);
      #1 xvld = 1'b0;
      step();
    end

    // sb x5 -> 0x1002, ack on third BUSY cycle
    sena = 1'b0; stl_cnt = 0;
    issue(5'h08, 3'd0, 32'h0000_1002, 32'h0000_0005);
    @(negedge sclk); if (dstl) stl_cnt++;
    step();
    @(negedge sclk); if (dstl) stl_cnt++;
    chk("sb_cyc", {31'b0, dwb_cyc}, 32'd1);
    chk("sb_stb", {31'b0, dwb_stb}, 32'd1);
    chk("sb_wre", {31'b0, dwb_wre}, 32'd1);
    chk("sb_sel", {28'b0, dwb_sel}, 32'h4);
    chk("sb_dto", dwb_dto, 32'h0505_0505);
    chk("sb_adr", dwb_adr, 32'h0000_1000);
    step();
    @(negedge sclk); if (dstl) stl_cnt++;
    step();
    dwb_ack = 1'b1; sena = 1'b1;
    @(negedge sclk); if (dstl) stl_cnt++;
    step();
    dwb_ack = 1'b0; xvld = 1'b0;
    @(negedge sclk);
    chk("sb_stl_cycles", stl_cnt, 32'd3);
    chk("sb_done_cyc", {31'b0, dwb_cyc}, 32'd0);
    step();

    // lw 0x100, ack with sena low -> HOLD
    sena = 1'b0;
    issue(5'h00, 3'd2, 32'h0000_0100, 32'h0);
    step();
    dwb_ack = 1'b1; dwb_dti = 32'hDEAD_BEEF;
    @(negedge sclk);
    chk("lw_ack_ddat", ddat, 32'hDEAD_BEEF);
    chk("lw_ack_dstl", {31'b0, dstl}, 32'd0);
    step();
    dwb_ack = 1'b0; dwb_dti = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge sclk);
      chk($sformatf("hold%0d_ddat", k), ddat, 32'hDEAD_BEEF);
      chk($sformatf("hold%0d_xsel", k), {28'b0, xsel}, 32'hF);
      chk($sformatf("hold%0d_cyc", k), {31'b0, dwb_cyc}, 32'd0);
      chk($sformatf("hold%0d_dstl", k), {31'b0, dstl}, 32'd0);
      step();
    end
    sena = 1'b1;
    step();
    xvld = 1'b0; xfn3 = 3'd0; xadd = 32'h0000_0101;
    @(negedge sclk);
    chk("hold_exit_xsel", {28'b0, xsel}, 32'h2);
    step();

    // lh 0x103 misaligned
    issue(5'h00, 3'd1, 32'h0000_0103, 32'h0);
    @(negedge sclk);
    chk("mis_dmis", {31'b0, dmis}, 32'd1);
    chk("mis_dstl", {31'b0, dstl}, 32'd0);
    step();
    xvld = 1'b0;
    @(negedge sclk);
    chk("mis_dmis_end", {31'b0, dmis}, 32'd0);
    chk("mis_cyc", {31'b0, dwb_cyc}, 32'd0);
    step();

    // watchdog: no ack, limit 4
    busy_cnt = 0; derr_cnt = 0; derr_at = 0;
    issue(5'h00, 3'd2, 32'h0000_0200, 32'h0);
    step();
    xvld = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sclk);
      if (dwb_cyc) busy_cnt++;
      if (derr) begin derr_cnt++; derr_at = busy_cnt; end
      step();
    end
    chk("wd_busy_cycles", busy_cnt, 32'd4);
    chk("wd_derr_pulses", derr_cnt, 32'd1);
    chk("wd_derr_cycle", derr_at, 32'd4);
    @(negedge sclk);
    chk("wd_idle_cyc", {31'b0, dwb_cyc}, 32'd0);
    step();

    // asynchronous reset during BUSY
    sena = 1'b0;
    issue(5'h00, 3'd2, 32'h0000_0300, 32'h0);
    step();
    @(negedge sclk);
    chk("ar_busy_cyc", {31'b0, dwb_cyc}, 32'd1);
    #2 srst = 1'b1;
    #1;
    chk("ar_cyc", {31'b0, dwb_cyc}, 32'd0);
    chk("ar_stb", {31'b0, dwb_stb}, 32'd0);
    chk("ar_dstl", {31'b0, dstl}, 32'd0);
    step();
    xvld = 1'b0; srst = 1'b0;
    step();

    // err and ack together
    issue(5'h00, 3'd2, 32'h0000_0400, 32'h0);
    step();
    dwb_ack = 1'b1; dwb_err = 1'b1;
    @(negedge sclk);
    chk("ea_derr", {31'b0, derr}, 32'd1);
    chk("ea_dstl", {31'b0, dstl}, 32'd0);
    step();
    dwb_ack = 1'b0; dwb_err = 1'b0; xvld = 1'b0; xfn3 = 3'd0; xadd = 32'h0000_0101;
    @(negedge sclk);
    chk("ea_derr_end", {31'b0, derr}, 32'd0);
    chk("ea_cyc", {31'b0, dwb_cyc}, 32'd0);
    chk("ea_not_hold", {28'b0, xsel}, 32'h2);
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
